// File: rtl/rand_pkg.sv
// Shared types and helpers for the random-number server: LFSR taps, FSM states, rejection mask.
package rand_pkg;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    ACK
  } state_e;

  // All ones at and below the MSB of (r-1); r == 0 stands for the full range.
  function automatic logic [31:0] smear_mask(input logic [31:0] r);
    logic [31:0] m;
    if (r == 32'h0) begin
      m = '1;
    end else begin
      m = r - 32'h1;
      for (int unsigned sh = 1; sh < 32; sh = sh * 2) begin
        m = m | (m >> sh);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr+1 (mod N).
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int unsigned PW = $clog2(N);

  logic          w_found;
  int unsigned   w_k;
  logic [PW-1:0] w_kidx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    w_kidx  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_k = 32'(i_ptr) + i;
      if (w_k >= N) begin
        w_k = w_k - N;
      end
      w_kidx = PW'(w_k);
      if (!w_found && i_req[w_kidx]) begin
        w_found         = 1'b1;
        o_grant[w_kidx] = 1'b1;
        o_idx           = w_kidx;
      end
    end
  end

endmodule

// File: rtl/rand_server.sv
// Shared LFSR random-number server: round-robin grants, masked rejection sampling with bounded retries.
module rand_server
  import rand_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned W          = 4,
  parameter int unsigned MAX_TRIES  = 8,
  parameter bit          FREE_RUN   = 1'b1,
  parameter logic [31:0] INIT_STATE = 32'haaaa_aaaa
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] range,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   data,
  input  logic           seed_load,
  input  logic [31:0]    seed,
  output logic           busy
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned TW = $clog2(MAX_TRIES) + 1;

  state_e        r_state;
  logic [31:0]   r_lfsr;
  logic [W-1:0]  r_range;
  logic [N-1:0]  r_grant;
  logic [PW-1:0] r_idx;
  logic [PW-1:0] r_ptr;
  logic [TW-1:0] r_tries;

  logic [N-1:0]  w_grant;
  logic [PW-1:0] w_idx;
  logic [W-1:0]  w_ranges [N];
  logic [W-1:0]  w_mask;
  logic [W-1:0]  w_sample;
  logic          w_accept;
  logic          w_last;
  logic [31:0]   w_lfsr_next;

  for (genvar gi = 0; gi < N; gi++) begin : g_range
    assign w_ranges[gi] = range[gi*W +: W];
  end

  rr_arbiter #(.N(N)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);
  assign w_mask      = W'(smear_mask(32'(r_range)));
  assign w_sample    = r_lfsr[W-1:0] & w_mask;
  assign w_accept    = (r_range == '0) || (w_sample < r_range);
  assign w_last      = (r_tries == TW'(MAX_TRIES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_lfsr  <= INIT_STATE;
      r_range <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= PW'(N - 1);
      r_tries <= '0;
      ack     <= '0;
      data    <= '0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;

      // Seed load beats stepping; a zero seed would lock the LFSR, so substitute INIT_STATE.
      if (seed_load) begin
        r_lfsr <= (seed == 32'h0) ? INIT_STATE : seed;
      end else if (r_state == DRAW || (FREE_RUN && r_state == IDLE)) begin
        r_lfsr <= w_lfsr_next;
      end

      case (r_state)
        IDLE: begin
          if (|req) begin
            r_range <= w_ranges[w_idx];
            r_grant <= w_grant;
            r_idx   <= w_idx;
            r_tries <= '0;
            busy    <= 1'b1;
            r_state <= DRAW;
          end
        end
        DRAW: begin
          if (w_accept || w_last) begin
            // Fallback subtraction stays below r because the masked sample is below 2r.
            data    <= w_accept ? w_sample : (w_sample - r_range);
            ack     <= r_grant;
            r_ptr   <= r_idx;
            r_state <= ACK;
          end else begin
            r_tries <= r_tries + TW'(1);
          end
        end
        ACK: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_server.sv
// Directed bench for rand_server: reset, full-range draw, rejection, fallback, seeding, round-robin, mid-draw reset.
module tb_rand_server;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] req;
  logic [1:0] req_fb;
  logic [7:0] range;
  logic       seed_load;
  logic [31:0] seed;
  logic [1:0] ack, ack_fb;
  logic [3:0] data, data_fb;
  logic       busy, busy_fb;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  rand_server #(.N(2), .W(4), .MAX_TRIES(8), .FREE_RUN(1'b0)) dut (
    .CLK(CLK), .RST(RST), .req(req), .range(range), .ack(ack), .data(data),
    .seed_load(seed_load), .seed(seed), .busy(busy)
  );

  rand_server #(.N(2), .W(4), .MAX_TRIES(2), .FREE_RUN(1'b0)) dut_fb (
    .CLK(CLK), .RST(RST), .req(req_fb), .range(range), .ack(ack_fb), .data(data_fb),
    .seed_load(seed_load), .seed(seed), .busy(busy_fb)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] v);
    seed_load = 1'b1;
    seed      = v;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    vectors++;
    if (ack !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b expected 00", ack); end
    vectors++;
    if (data !== 4'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", data); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_full_range();
    load_seed(32'h0000_000A);
    range = 8'h00;
    req   = 2'b01;
    tick();
    vectors++;
    if (ack !== 2'b00 || busy !== 1'b1) begin
      miscompares++; $display("FAIL full_draw_cycle: ack %b busy %b expected 00 1", ack, busy);
    end
    tick();
    vectors++;
    if (ack !== 2'b01) begin miscompares++; $display("FAIL full_ack: got %b expected 01", ack); end
    vectors++;
    if (data !== 4'hA) begin miscompares++; $display("FAIL full_data: got %h expected a", data); end
    req = 2'b00;
    tick();
    vectors++;
    if (ack !== 2'b00 || busy !== 1'b0) begin
      miscompares++; $display("FAIL full_after_ack: ack %b busy %b expected 00 0", ack, busy);
    end
  endtask

  task automatic test_rejection();
    int n;
    load_seed(32'h0000_000E);
    range = 8'h05;
    req   = 2'b01;
    n = 0;
    do begin tick(); n++; end while (ack == 2'b00 && n < 12);
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL reject_latency: got %0d expected 4", n); end
    vectors++;
    if (ack !== 2'b01 || data !== 4'h0) begin
      miscompares++; $display("FAIL reject_result: ack %b data %h expected 01 0", ack, data);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_fallback();
    int n;
    load_seed(32'h0000_000E);
    range  = 8'h05;
    req_fb = 2'b01;
    n = 0;
    do begin tick(); n++; end while (ack_fb == 2'b00 && n < 12);
    vectors++;
    if (n != 3) begin miscompares++; $display("FAIL fallback_latency: got %0d expected 3", n); end
    vectors++;
    if (ack_fb !== 2'b01 || data_fb !== 4'h2) begin
      miscompares++; $display("FAIL fallback_result: ack %b data %h expected 01 2", ack_fb, data_fb);
    end
    req_fb = 2'b00;
    tick();
  endtask

  task automatic test_seed_zero();
    logic [3:0] exp [3];
    int n;
    exp[0] = 4'hA;
    exp[1] = 4'h5;
    exp[2] = 4'h9;
    load_seed(32'h0000_0000);
    range = 8'h00;
    for (int i = 0; i < 3; i++) begin
      req = 2'b01;
      n = 0;
      do begin tick(); n++; end while (ack == 2'b00 && n < 12);
      vectors++;
      if (ack !== 2'b01 || data !== exp[i]) begin
        miscompares++; $display("FAIL seed_zero_draw%0d: ack %b data %h expected 01 %h", i, ack, data, exp[i]);
      end
      req = 2'b00;
      tick();
    end
  endtask

  task automatic test_seed_in_draw();
    load_seed(32'h0000_000E);
    range = 8'h05;
    req   = 2'b01;
    tick();
    seed_load = 1'b1;
    seed      = 32'h0000_0003;
    tick();
    seed_load = 1'b0;
    vectors++;
    if (ack !== 2'b00) begin miscompares++; $display("FAIL seed_draw_early: got %b expected 00", ack); end
    tick();
    vectors++;
    if (ack !== 2'b01 || data !== 4'h3) begin
      miscompares++; $display("FAIL seed_draw_result: ack %b data %h expected 01 3", ack, data);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    int n;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    range = 8'h11;
    req   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      n = 0;
      do begin tick(); n++; end while (ack == 2'b00 && n < 12);
      vectors++;
      if (ack !== exp || data !== 4'h0) begin
        miscompares++; $display("FAIL rr_grant%0d: ack %b data %h expected %b 0", i, ack, data, exp);
      end
      req = req & ~exp;
      tick();
      tick();
      req = 2'b11;
    end
    req = 2'b00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_draw();
    int n;
    load_seed(32'h0000_000A);
    range = 8'h50;
    req   = 2'b01;
    n = 0;
    do begin tick(); n++; end while (ack == 2'b00 && n < 12);
    vectors++;
    if (ack !== 2'b01 || data !== 4'hA) begin
      miscompares++; $display("FAIL pre_reset_draw: ack %b data %h expected 01 a", ack, data);
    end
    req = 2'b00;
    tick();
    load_seed(32'h0000_000E);
    req = 2'b10;
    tick();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_draw_busy: got %b expected 1", busy); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++;
    if (ack !== 2'b00 || busy !== 1'b0 || data !== 4'h0) begin
      miscompares++; $display("FAIL mid_draw_reset: ack %b busy %b data %h expected 00 0 0", ack, busy, data);
    end
    req = 2'b11;
    n = 0;
    do begin tick(); n++; end while (ack == 2'b00 && n < 12);
    vectors++;
    if (ack !== 2'b01) begin miscompares++; $display("FAIL post_reset_grant: got %b expected 01", ack); end
    req = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    RST       = 1'b1;
    req       = 2'b00;
    req_fb    = 2'b00;
    range     = 8'h00;
    seed_load = 1'b0;
    seed      = 32'h0;
    test_reset();
    test_full_range();
    test_rejection();
    test_fallback();
    test_seed_zero();
    test_seed_in_draw();
    test_round_robin();
    test_reset_mid_draw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rand_server.md
# rand_server

Shared random-number server for the game logic. It owns one 32-bit Galois LFSR with taps 32, 22, 2 and 1. It round-robin arbitrates among N requesters, such as the piece generator and the garbage-row generator. Each grant returns one unbiased W-bit value in [0, range) using masked rejection sampling, with a bounded-retry fallback.

## Interface
Parameters:
- N, 2: number of requesters (2..8).
- W, 4: width of the returned value and of each range field.
- MAX_TRIES, 8: draw cycles per grant before the fallback is taken (at least 1).
- FREE_RUN, 1: when 1, the LFSR also steps every cycle in IDLE, so player timing adds entropy.
- INIT_STATE, 32'haaaa_aaaa: LFSR value after reset, and the value substituted for a zero seed.

Ports:
- CLK, in, 1: the single clock.
- RST, in, 1: reset, synchronous and active-high.
- req, in, N: request per requester; held high until that requester's ack.
- range, in, N*W: field i is requester i's exclusive upper bound; 0 means 2^W (full range).
- ack, out, N: one-hot, high for exactly one cycle, marks data valid for that requester.
- data, out, W: result; holds its value until the next ack.
- seed_load, in, 1: load seed into the LFSR this cycle.
- seed, in, 32: seed value.
- busy, out, 1: high in DRAW and ACK.

## Operation
- The FSM has three states: IDLE, DRAW and ACK.
- LFSR step: next = (s >> 1) ^ (s[0] ? TAPS : 0), where TAPS = 32'h8020_0003.
- IDLE
  - If req is nonzero, the arbiter picks g = first set bit at or after ptr+1 (mod N).
  - On that grant: latch r = range[g], clear tries, and go to DRAW.
  - The arbiter pointer ptr updates only at ack, to ptr = g.
- DRAW runs every cycle:
  - sample = s[W-1:0] & mask.
  - mask = all ones if r == 0; otherwise the smear of (r-1), i.e. all bits at and below the MSB of r-1.
  - Accept if r == 0 or sample < r: data <= sample.
  - Otherwise, if tries == MAX_TRIES-1: data <= sample - r. This cannot underflow and is always < r, because sample < 2r.
  - Otherwise: tries <= tries+1 and stay in DRAW.
  - On accept or fallback: ack[g] <= 1 and go to ACK.
  - The LFSR steps every DRAW cycle, regardless of FREE_RUN.
- ACK: ack is high for this one cycle, req is not sampled, next state is IDLE.
- req dropping low in DRAW does not abort; the ack is still issued.
- seed_load
  - Legal in any state and has priority over stepping: s <= (seed == 0) ? INIT_STATE : seed.
  - A draw in progress continues from the new state on the next cycle.
- The LFSR never holds zero.
- Reset values: FSM IDLE, s = INIT_STATE, ack = 0, data = 0, busy = 0, tries = 0, ptr = N-1 (so requester 0 has highest priority first).

## Timing
- Request first seen in IDLE at cycle t:
  - First DRAW at t+1.
  - ack at t+1+k+1, where k is the number of rejections, 0 ≤ k ≤ MAX_TRIES-1.
  - Minimum latency req to ack is 2 cycles; maximum is MAX_TRIES+1.
- data and ack are registered, change on the same edge, and data is stable while ack is high.
- The requester clears req on the edge ending its ack cycle. The following IDLE cycle then sees the updated req, so no double grant occurs.
- Throughput is one grant per 3 cycles minimum.
- Simultaneous seed_load and DRAW decision: the decision uses the pre-load s; the load wins over the step.
- RST asserted mid-DRAW or mid-ACK: the next cycle is in reset state, with no ack and no partial result.

## Structure
- Package rand_pkg holds:
  - TAPS.
  - The FSM state enum (IDLE, DRAW, ACK).
  - A function computing the smear mask of (r-1).
- Sub-module rr_arbiter (N): inputs req and ptr, output one-hot grant plus its index, purely combinational.
- The LFSR register and step logic live inline, because the block needs the synchronous active-high reset and the seed-load priority.

## Test plan
- Full-range draw: FREE_RUN=0, load seed 32'h0000_000A, req[0]=1 with range[0]=0 → ack[0] 2 cycles later, data=4'hA.
- Rejection: FREE_RUN=0, seed 32'h0000_000E, range=5 (mask 7) → samples 6 and 7 are rejected, state reaches 32'h8020_0000, data=0; ack 4 cycles after req.
- Fallback: same stimulus with MAX_TRIES=2 → sample 6 rejected, sample 7 takes the fallback, data=2; ack 3 cycles after req.
- Round-robin: req=2'b11 held, each requester dropping and re-raising its req after its ack → acks alternate 0,1,0,1 with no repeat; range=1 always returns data=0.
- Seed: seed_load with seed=0 → LFSR equals INIT_STATE. A seed_load during DRAW → the next sample comes from the new seed.
- Reset mid-DRAW: RST high for one cycle in DRAW → ack stays 0, busy=0, data=0, and the next grant goes to requester 0.
